// File: rtl/nn_infer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : nn_infer_scheduler
// Purpose  : Round-robin scheduler sharing one neural_net_2layer inference
//            engine among NUM_REQ requesters. One inference is outstanding at
//            a time: IDLE (arbitrate/accept) -> ISSUE -> WAIT -> RESP.
// Ports    : clk, rst_n          clock, synchronous active-low reset
//            req_valid/ready     per-requester input handshake
//            req_data            NUM_REQ x 4 x int8; requester i occupies
//                                [i*32 +: 32], element j at [j*8 +: 8]
//            resp_valid/ready    per-requester result handshake
//            resp_data           2 x int16, element j at [j*16 +: 16]
//            eng_in_*            to engine input_valid / input_data
//            eng_out_*           from engine output_valid / output_data
//            busy                state != IDLE
//            done_count          completed response handshakes (wraps)
//            timeout_err         sticky engine-timeout flag
// Options  : NN_SCHED_TIMEOUT_EN - bound WAIT to TIMEOUT_CYCLES cycles; when
//            undefined WAIT is unbounded and timeout_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module nn_infer_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [31:0]           resp_data,
    output logic                  eng_in_valid,
    output logic [31:0]           eng_in_data,
    input  logic                  eng_out_valid,
    input  logic [31:0]           eng_out_data,
    output logic                  busy,
    output logic [15:0]           done_count,
    output logic                  timeout_err
);

    localparam int C_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("nn_infer_scheduler: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("nn_infer_scheduler: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_IDX_W-1:0]   r_rr_ptr;
    logic [C_IDX_W-1:0]   r_grant;
    logic [C_IDX_W-1:0]   w_arb_idx;
    logic [C_IDX_W-1:0]   w_probe;
    logic                 w_arb_found;
    logic [31:0]          w_arb_data;
    logic [31:0]          r_hold;
    logic [31:0]          r_result;
    logic [15:0]          r_done_count;
    logic                 w_accept;
    logic                 w_resp_hs;
    logic                 w_eng_hit;
    logic                 w_tmo_hit;

    // Rotating priority search: the first valid requester at or after rr_ptr.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_probe     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_probe = C_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_arb_found && req_valid[w_probe]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_probe;
            end
        end
    end

    always_comb begin
        w_arb_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_idx == C_IDX_W'(i)) begin
                w_arb_data = req_data[i*32 +: 32];
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = '0;
        resp_valid   = '0;
        eng_in_valid = 1'b0;
        w_accept     = 1'b0;
        w_resp_hs    = 1'b0;
        w_eng_hit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by rst_n so nothing is offered while reset is held.
                if (rst_n && w_arb_found) begin
                    req_ready[w_arb_idx] = 1'b1;
                    w_accept             = 1'b1;
                    w_state_nxt          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_in_valid = 1'b1;
                w_state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (eng_out_valid) begin
                    w_eng_hit   = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid[r_grant] = 1'b1;
                if (resp_ready[r_grant]) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_hold       <= '0;
            r_result     <= '0;
            r_done_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_hold  <= w_arb_data;
                r_grant <= w_arb_idx;
            end
            if (w_eng_hit) begin
                r_result <= eng_out_data;
            end else if (r_state == S_WAIT && w_tmo_hit) begin
                r_result <= '0;
            end
            if (w_resp_hs) begin
                r_done_count <= r_done_count + 16'd1;
                // The requester just served drops to lowest priority.
                r_rr_ptr <= (int'(r_grant) == NUM_REQ - 1) ? '0 : r_grant + 1'b1;
            end
        end
    end

`ifdef NN_SCHED_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_TMO_W-1:0] r_wait_cnt;
    logic               r_timeout_err;
    logic               w_timeout;

    // r_wait_cnt counts completed WAIT cycles; the last allowed one is
    // TIMEOUT_CYCLES-1, so RESP starts exactly TIMEOUT_CYCLES after WAIT entry.
    assign w_tmo_hit = (r_wait_cnt == C_TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout = (r_state == S_WAIT) && !eng_out_valid && w_tmo_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT && !w_tmo_hit) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy        = (r_state != S_IDLE);
    assign done_count  = r_done_count;
    assign eng_in_data = r_hold;
    assign resp_data   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_nn_infer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_infer_scheduler
// Purpose  : Self-checking bench for nn_infer_scheduler. A 1-cycle behavioural
//            stand-in for the engine computes y0 = 2*x0 + x1 + 2*x3 and
//            y1 = 4*(x0+x1+x2) + 5*x3 (so {1,2,3,4} -> {12,44}). Expected
//            results are queued at accept and compared at the response
//            handshake. Timeout cases are built when NN_SCHED_TIMEOUT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_infer_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]    resp_ready = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [31:0]     resp_data;
    logic            eng_in_valid;
    logic [31:0]     eng_in_data;
    logic            eng_out_valid = 1'b0;
    logic [31:0]     eng_out_data = '0;
    logic            busy;
    logic [15:0]     done_count;
    logic            timeout_err;

    bit              eng_silent = 1'b0;
    bit              eng_inject = 1'b0;
    int              n_checks = 0;
    int              n_errors = 0;
    int              cyc = 0;

    nn_infer_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .eng_in_valid (eng_in_valid),
        .eng_in_data  (eng_in_data),
        .eng_out_valid(eng_out_valid),
        .eng_out_data (eng_out_data),
        .busy         (busy),
        .done_count   (done_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] eng_fn(input logic [31:0] v);
        logic signed [15:0] x0, x1, x2, x3, y0, y1;
        x0 = {{8{v[7]}},  v[7:0]};
        x1 = {{8{v[15]}}, v[15:8]};
        x2 = {{8{v[23]}}, v[23:16]};
        x3 = {{8{v[31]}}, v[31:24]};
        y0 = 16'sd2 * x0 + x1 + 16'sd2 * x3;
        y1 = 16'sd4 * (x0 + x1 + x2) + 16'sd5 * x3;
        return {y1, y0};
    endfunction

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Engine stand-in: one-cycle latency, optionally silent, plus a raw
    // output_valid injector.
    always @(posedge clk) begin
        eng_out_valid <= (eng_in_valid && !eng_silent) || eng_inject;
        eng_out_data  <= eng_fn(eng_in_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard and reference round-robin pointer.
    int          sb_req[$];
    logic [31:0] sb_data[$];
    int          grant_log[$];
    int          gtime_log[$];
    int          exp_ptr = 0;
    int          t_acc = 0;
    int          exp_lat = 3;
    bit          resp_seen = 1'b0;
    logic [31:0] last_vec = '0;
    logic [15:0] exp_done = '0;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            sb_req.delete();
            sb_data.delete();
            exp_ptr   = 0;
            resp_seen = 1'b0;
            exp_done  = '0;
        end else begin
            if (req_ready != '0) begin
                int g;
                g = -1;
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(exp_ptr + k) % N]) g = (exp_ptr + k) % N;
                end
                chk("grant", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
                if (g >= 0) begin
                    last_vec = req_data[g*32 +: 32];
                    sb_req.push_back(g);
                    sb_data.push_back(eng_silent ? 32'd0 : eng_fn(last_vec));
                    grant_log.push_back(g);
                    gtime_log.push_back(cyc);
                    t_acc = cyc;
                end
            end
            if (eng_in_valid) begin
                chk("issue_lat", 32'(cyc - t_acc), 32'd1);
                chk("eng_in_data", eng_in_data, last_vec);
            end
            if (resp_valid != '0 && !resp_seen) begin
                resp_seen = 1'b1;
                chk("resp_lat", 32'(cyc - t_acc), 32'(exp_lat));
            end
            if ((resp_valid & resp_ready) != '0) begin
                if (sb_req.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    int          r;
                    logic [31:0] d;
                    r = sb_req.pop_front();
                    d = sb_data.pop_front();
                    chk("resp_who", 32'(resp_valid), 32'd1 << r);
                    chk("resp_data", resp_data, d);
                    exp_ptr  = (r + 1) % N;
                    exp_done = exp_done + 16'd1;
                end
                resp_seen = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a vector on requester i and hold it until accepted.
    task automatic send(input int i, input logic [31:0] v);
        bit got;
        got = 1'b0;
        req_data[i*32 +: 32] = v;
        req_valid[i] = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            #1;
            if (req_ready[i]) got = 1'b1;
            else @(negedge clk);
        end
        chk("accept_timeout", 32'(got), 32'd1);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((sb_req.size() != 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(t < budget), 32'd1);
        chk("done_count", 32'(done_count), 32'(exp_done));
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_eng_in_valid", 32'(eng_in_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_count", 32'(done_count), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_eng_in_data", eng_in_data, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        logic [31:0] v0;
        int          w;

        // Reset values.
        rst_n = 1'b0;
        step(3);
        chk_reset_vals();
        rst_n = 1'b1;
        step(1);
        resp_ready = '1;

        // Single request on requester 2.
        send(2, pack4(1, 2, 3, 4));
        wait_drain(20);
        chk("single_data", resp_data, 32'h002C_000C);
        chk("single_done", 32'(done_count), 32'd1);

        // Round-robin with all requesters continuously valid.
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*32 +: 32] = pack4(i + 1, -(i + 2), 3 * i, 7 - i);
        grant_log.delete();
        gtime_log.delete();
        req_valid = '1;
        for (int t = 0; t < 40 && grant_log.size() < 5; t++) begin
            @(negedge clk);
            #1;
            if (grant_log.size() >= 1) chk("rr_busy", 32'(busy), 32'(req_ready == '0));
        end
        @(negedge clk);
        req_valid = '0;
        chk("rr_count", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", 32'(grant_log[i]), 32'(i % N));
            for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(gtime_log[i] - gtime_log[i-1]), 32'd4);
        end
        wait_drain(40);

        // Backpressure on requester 0 with requester 1 pending.
        do_reset();
        resp_ready = 4'b1110;
        v0 = pack4(5, -6, 7, -8);
        send(0, v0);
        req_data[1*32 +: 32] = pack4(10, 20, 30, 40);
        req_valid[1] = 1'b1;
        w = 0;
        while (resp_valid == '0 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("bp_resp_seen", 32'(resp_valid), 32'd1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'd1);
            chk("bp_resp_data", resp_data, eng_fn(v0));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'b0010);
        send(1, pack4(10, 20, 30, 40));
        wait_drain(20);

        // Reset while the engine result is outstanding.
        eng_silent = 1'b1;
        send(3, pack4(9, 9, 9, 9));
        step(2);
        chk("wait_busy", 32'(busy), 32'd1);
`ifndef NN_SCHED_TIMEOUT_EN
        step(20);
        chk("nobound_busy", 32'(busy), 32'd1);
        chk("nobound_resp", 32'(resp_valid), 32'd0);
        chk("nobound_tmo", 32'(timeout_err), 32'd0);
`endif
        rst_n = 1'b0;
        req_valid = '1;
        step(2);
        chk_reset_vals();
        req_valid = '0;
        rst_n = 1'b1;
        eng_inject = 1'b1;
        step(1);
        eng_inject = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("post_rst_resp", 32'(resp_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        eng_silent = 1'b0;
        grant_log.delete();
        req_data[3*32 +: 32] = pack4(-9, 8, -7, 6);
        req_valid[3] = 1'b1;
        send(1, pack4(3, -3, 3, -3));
        chk("post_rst_first", 32'(grant_log[0]), 32'd1);
        send(3, pack4(-9, 8, -7, 6));
        wait_drain(30);

`ifdef NN_SCHED_TIMEOUT_EN
        // Silent engine: RESP after TIMEOUT_CYCLES WAIT cycles with zeros.
        eng_silent = 1'b1;
        exp_lat    = 2 + 15;
        send(0, pack4(1, 1, 1, 1));
        wait_drain(40);
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_data", resp_data, 32'd0);
        eng_silent = 1'b0;
        exp_lat    = 3;
`endif

        // done_count wrap.
        force dut.r_done_count = 16'hFFFF;
        step(1);
        release dut.r_done_count;
        step(1);
        chk("wrap_pre", 32'(done_count), 32'h0000_FFFF);
        exp_done = 16'hFFFF;
        send(2, pack4(-1, -2, -3, -4));
        wait_drain(20);
        chk("wrap_post", 32'(done_count), 32'd0);
`ifdef NN_SCHED_TIMEOUT_EN
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
